// File: rtl/hello_pkg.sv
// hello_pkg: message ROM contents, message length and FSM state encoding
// shared by the hello_stream generator.
package hello_pkg;

   localparam int HELLO_MSG_LEN = 16;

   // "Hello from RTL\r\n", byte [0] = 'H' ... byte [15] = '\n'
   localparam logic [HELLO_MSG_LEN-1:0][7:0] HELLO_MSG = {
      8'h0A, 8'h0D, 8'h4C, 8'h54, 8'h52, 8'h20, 8'h6D, 8'h6F,
      8'h72, 8'h66, 8'h20, 8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h48
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } hello_state_e;

endpackage

// File: rtl/hello_stream.sv
// hello_stream: streams the fixed greeting from hello_pkg over a valid/ready
// byte interface, REPEAT copies per start (0 = forever) with GAP_CYCLES idle
// cycles between copies. All outputs are registered.
// Optional build macro HELLO_STREAM_SIM_LOG_EN adds a simulation-only log of
// each completed copy; logic and timing are unchanged by it.
module hello_stream
   import hello_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int MSG_LEN    = 16,
   parameter int REPEAT     = 1,
   parameter int GAP_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] tdata_o,
   output logic              tvalid_o,
   input  logic              tready_i,
   output logic              tlast_o,
   output logic [15:0]       msg_cnt_o
);

   localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(MSG_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
   localparam logic [15:0]      REPEAT_CNT = 16'(REPEAT);

   // Parameter legality is enforced at elaboration.
   if (DATA_W != 8) begin : g_bad_data_w
      $error("hello_stream: DATA_W must be 8");
   end
   if (MSG_LEN < 1 || MSG_LEN > 64 || MSG_LEN != HELLO_MSG_LEN) begin : g_bad_msg_len
      $error("hello_stream: MSG_LEN must be 1..64 and equal HELLO_MSG_LEN");
   end
   if (REPEAT < 0 || REPEAT > 65535) begin : g_bad_repeat
      $error("hello_stream: REPEAT must be 0..65535");
   end
   if (GAP_CYCLES < 0) begin : g_bad_gap
      $error("hello_stream: GAP_CYCLES must be non-negative");
   end

   hello_state_e      state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [15:0]       copy_q, copy_d;
   logic [15:0]       msg_cnt_q, msg_cnt_d;
   logic [DATA_W-1:0] tdata_q, tdata_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Next-state logic; outputs for the next cycle are derived from the next state and index.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
      copy_d    = copy_q;
      msg_cnt_d = msg_cnt_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = SEND;
               idx_d   = '0;
               gap_d   = '0;
               copy_d  = '0;
            end
         end
         SEND: begin
            if (tvalid_q && tready_i) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (msg_cnt_q != 16'hFFFF) begin
                     msg_cnt_d = msg_cnt_q + 16'd1;
                  end
                  if (copy_q != 16'hFFFF) begin
                     copy_d = copy_q + 16'd1;
                  end
                  if (REPEAT != 0 && copy_d == REPEAT_CNT) begin
                     state_d = DONE;
                  end else if (GAP_CYCLES > 0) begin
                     state_d = GAP;
                     gap_d   = '0;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = SEND;
               gap_d   = '0;
               idx_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
      tvalid_d = (state_d == SEND);
      tdata_d  = tvalid_d ? DATA_W'(HELLO_MSG[idx_d]) : '0;
      tlast_d  = tvalid_d && (idx_d == LAST_IDX);
   end

   // State, counters and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         gap_q     <= '0;
         copy_q    <= '0;
         msg_cnt_q <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         gap_q     <= gap_d;
         copy_q    <= copy_d;
         msg_cnt_q <= msg_cnt_d;
         tdata_q   <= tdata_d;
         tvalid_q  <= tvalid_d;
         tlast_q   <= tlast_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign tdata_o   = tdata_q;
   assign tvalid_o  = tvalid_q;
   assign tlast_o   = tlast_q;
   assign msg_cnt_o = msg_cnt_q;

`ifdef HELLO_STREAM_SIM_LOG_EN
   initial $display("[%0t] hello_stream: greeting stream generator present", $time);

   // Log every completed copy as its last character is accepted.
   always @(posedge clk) begin
      if (rst_n && tvalid_q && tready_i && tlast_q) begin
         $display("[%0t] hello_stream: message %0d sent", $time, msg_cnt_d);
      end
   end
`else
`endif

endmodule

// File: tb/tb_hello_stream.sv
// tb_hello_stream: three hello_stream instances (default, REPEAT=3/GAP=4,
// REPEAT=2/GAP=0) driven by directed start/backpressure patterns; received
// bytes are matched against a queue of expected characters.
module tb_hello_stream;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start   [3];
   logic        tready  [3];
   logic        busy    [3];
   logic        done    [3];
   logic [7:0]  tdata   [3];
   logic        tvalid  [3];
   logic        tlast   [3];
   logic [15:0] msgCnt  [3];

   int   sel;
   exp_t sbq[$];
   int   assertCount;
   int   failCount;

   int doneAt, busyLowAt, firstValidAt, lastAt;
   int xferCount, lastCount, doneCount, bubbleCount;
   logic [7:0] firstData;

   logic [7:0] expMsg [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h66, 8'h72,
                               8'h6F, 8'h6D, 8'h20, 8'h52, 8'h54, 8'h4C, 8'h0D, 8'h0A};

   hello_stream u_dut0 (
      .clk(clk), .rst_n(rst_n), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
      .tdata_o(tdata[0]), .tvalid_o(tvalid[0]), .tready_i(tready[0]), .tlast_o(tlast[0]),
      .msg_cnt_o(msgCnt[0])
   );

   hello_stream #(.REPEAT(3), .GAP_CYCLES(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
      .tdata_o(tdata[1]), .tvalid_o(tvalid[1]), .tready_i(tready[1]), .tlast_o(tlast[1]),
      .msg_cnt_o(msgCnt[1])
   );

   hello_stream #(.REPEAT(2), .GAP_CYCLES(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start_i(start[2]), .busy_o(busy[2]), .done_o(done[2]),
      .tdata_o(tdata[2]), .tvalid_o(tvalid[2]), .tready_i(tready[2]), .tlast_o(tlast[2]),
      .msg_cnt_o(msgCnt[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Queue the expected characters for the selected instance, then pulse start for one cycle.
   task automatic applyStimulus(input int dutSel, input int copies);
      exp_t e;
      sel = dutSel;
      for (int c = 0; c < copies; c++) begin
         for (int i = 0; i < 16; i++) begin
            e.data = expMsg[i];
            e.last = (i == 15);
            sbq.push_back(e);
         end
      end
      tready[dutSel] = 1'b1;
      @(posedge clk); #1;
      start[dutSel] = 1'b1;
      @(posedge clk); #1;
      start[dutSel] = 1'b0;
   endtask

   // Run n cycles after the start edge; cycle j has tready low for stallFrom<=j<=stallTo.
   task automatic runCycles(input int n, input int stallFrom, input int stallTo, input int startAt);
      doneAt = -1; busyLowAt = -1; firstValidAt = -1; lastAt = -1; firstData = 8'h00;
      xferCount = 0; lastCount = 0; doneCount = 0; bubbleCount = 0;
      for (int j = 1; j <= n; j++) begin
         tready[sel] = (j < stallFrom) || (j > stallTo);
         start[sel]  = (j == startAt);
         @(negedge clk);
         if (tvalid[sel] && firstValidAt < 0) begin
            firstValidAt = j;
            firstData    = tdata[sel];
         end
         if (tvalid[sel] && tready[sel]) begin
            xferCount++;
            if (tlast[sel]) begin
               lastCount++;
               lastAt = j;
            end
         end
         if (done[sel]) begin
            doneCount++;
            if (doneAt < 0) doneAt = j;
         end
         if (!busy[sel] && busyLowAt < 0) busyLowAt = j;
         if (busy[sel] && !tvalid[sel] && !done[sel]) bubbleCount++;
         @(posedge clk); #1;
      end
      start[sel]  = 1'b0;
      tready[sel] = 1'b1;
   endtask

   // Compare every accepted character with the queue and check hold-under-stall.
   initial begin : monitor
      logic       prevStall;
      logic [7:0] prevData;
      logic       prevLast;
      exp_t       e;
      prevStall = 1'b0;
      prevData  = 8'h00;
      prevLast  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prevStall = 1'b0;
         end else begin
            if (prevStall) begin
               checkOutput("hold_valid", 32'(tvalid[sel]), 32'd1);
               checkOutput("hold_data", 32'(tdata[sel]), 32'(prevData));
               checkOutput("hold_last", 32'(tlast[sel]), 32'(prevLast));
            end
            if (tvalid[sel] && tready[sel]) begin
               checkOutput("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
               if (sbq.size() > 0) begin
                  e = sbq.pop_front();
                  checkOutput("sb_data", 32'(tdata[sel]), 32'(e.data));
                  checkOutput("sb_last", 32'(tlast[sel]), 32'(e.last));
               end
            end
            prevStall = tvalid[sel] && !tready[sel];
            prevData  = tdata[sel];
            prevLast  = tlast[sel];
         end
      end
   end

   initial begin
      assertCount = 0;
      failCount   = 0;
      sel         = 0;
      rst_n       = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start[i]  = 1'b0;
         tready[i] = 1'b1;
      end

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", 32'(busy[0]), 32'd0);
      checkOutput("rst_done", 32'(done[0]), 32'd0);
      checkOutput("rst_tdata", 32'(tdata[0]), 32'd0);
      checkOutput("rst_tvalid", 32'(tvalid[0]), 32'd0);
      checkOutput("rst_tlast", 32'(tlast[0]), 32'd0);
      checkOutput("rst_msgcnt", 32'(msgCnt[0]), 32'd0);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // Single copy, no backpressure
      $display("[TB] single message");
      applyStimulus(0, 1);
      runCycles(20, 0, -1, 0);
      checkOutput("t1_first_valid_at", 32'(firstValidAt), 32'd1);
      checkOutput("t1_first_data", 32'(firstData), 32'h48);
      checkOutput("t1_last_at", 32'(lastAt), 32'd16);
      checkOutput("t1_last_count", 32'(lastCount), 32'd1);
      checkOutput("t1_done_at", 32'(doneAt), 32'd17);
      checkOutput("t1_done_count", 32'(doneCount), 32'd1);
      checkOutput("t1_busy_low_at", 32'(busyLowAt), 32'd18);
      checkOutput("t1_msgcnt", 32'(msgCnt[0]), 32'd1);

      // Backpressure on cycles 3..7
      $display("[TB] backpressure");
      applyStimulus(0, 1);
      runCycles(26, 3, 7, 0);
      checkOutput("t2_xfers", 32'(xferCount), 32'd16);
      checkOutput("t2_last_at", 32'(lastAt), 32'd21);
      checkOutput("t2_done_at", 32'(doneAt), 32'd22);
      checkOutput("t2_msgcnt", 32'(msgCnt[0]), 32'd2);

      // REPEAT=3, GAP_CYCLES=4
      $display("[TB] repeat with gaps");
      applyStimulus(1, 3);
      runCycles(62, 0, -1, 0);
      checkOutput("t3_xfers", 32'(xferCount), 32'd48);
      checkOutput("t3_gap_cycles", 32'(bubbleCount), 32'd8);
      checkOutput("t3_last_count", 32'(lastCount), 32'd3);
      checkOutput("t3_done_count", 32'(doneCount), 32'd1);
      checkOutput("t3_done_at", 32'(doneAt), 32'd57);
      checkOutput("t3_msgcnt", 32'(msgCnt[1]), 32'd3);

      // REPEAT=2, GAP_CYCLES=0
      $display("[TB] back-to-back copies");
      applyStimulus(2, 2);
      runCycles(36, 0, -1, 0);
      checkOutput("t4_xfers", 32'(xferCount), 32'd32);
      checkOutput("t4_bubbles", 32'(bubbleCount), 32'd0);
      checkOutput("t4_last_at", 32'(lastAt), 32'd32);
      checkOutput("t4_done_at", 32'(doneAt), 32'd33);
      checkOutput("t4_msgcnt", 32'(msgCnt[2]), 32'd2);

      // Reset while character 7 is presented
      $display("[TB] reset mid-message");
      applyStimulus(0, 1);
      runCycles(7, 0, -1, 0);
      checkOutput("t5_pre_valid", 32'(tvalid[0]), 32'd1);
      checkOutput("t5_pre_data", 32'(tdata[0]), 32'h72);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_valid", 32'(tvalid[0]), 32'd0);
      checkOutput("t5_rst_busy", 32'(busy[0]), 32'd0);
      checkOutput("t5_rst_msgcnt", 32'(msgCnt[0]), 32'd0);
      sbq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(0, 1);
      runCycles(20, 0, -1, 0);
      checkOutput("t5_first_valid_at", 32'(firstValidAt), 32'd1);
      checkOutput("t5_first_data", 32'(firstData), 32'h48);
      checkOutput("t5_msgcnt", 32'(msgCnt[0]), 32'd1);

      // Start pulse while busy is ignored
      $display("[TB] start while busy");
      applyStimulus(0, 1);
      runCycles(25, 0, -1, 5);
      checkOutput("t6_xfers", 32'(xferCount), 32'd16);
      checkOutput("t6_last_count", 32'(lastCount), 32'd1);
      checkOutput("t6_done_count", 32'(doneCount), 32'd1);
      checkOutput("t6_msgcnt", 32'(msgCnt[0]), 32'd2);

      checkOutput("sb_empty", 32'(sbq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
